// File: rtl/cbrt_pkg.sv
// Shared types and constants for the cube-root stream controller.
// CBRT_RESULT_CHECK_EN adds the cube helper used by the result checker.
package cbrt_pkg;

  localparam int CBRT_DATA_W  = 8;
  localparam int BUSY_TIMEOUT = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

`ifdef CBRT_RESULT_CHECK_EN
  localparam int CUBE_W = 3 * CBRT_DATA_W + 2;

  function automatic logic [CUBE_W-1:0] cube(input logic [CBRT_DATA_W:0] v);
    logic [CUBE_W-1:0] w;
    w = CUBE_W'(v);
    return w * w * w;
  endfunction
`endif

endpackage

// File: rtl/cbrt_op_fifo.sv
// Operand FIFO: extra pointer MSB distinguishes full from empty.
// Head is read combinationally so the in-flight operand stays visible until popped.
module cbrt_op_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cbrt_stream_ctrl.sv
// Valid/ready front/back-end for the iterative cube-root core.
// Optional CBRT_RESULT_CHECK_EN adds a sticky err_o result checker.
module cbrt_stream_ctrl
  import cbrt_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = CBRT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [DATA_W-1:0] m_src_o,
  output logic              core_start_o,
  output logic [DATA_W-1:0] core_x_o,
  input  logic              core_busy_i,
  input  logic [DATA_W-1:0] core_y_i
`ifdef CBRT_RESULT_CHECK_EN
  ,
  output logic              err_o
`endif
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W-1:0] fifo_head;

  state_e            state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DATA_W-1:0] core_x_q, core_x_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] m_src_q, m_src_d;
  logic              capture, out_free;

  cbrt_op_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (s_valid_i),
    .data_i  (s_data_i),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign s_ready_o = !fifo_full;
  assign out_free  = !m_valid_q || m_ready_i;
  assign fifo_pop  = capture;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    core_x_d = core_x_q;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && out_free && !core_busy_i) begin
          state_d  = ISSUE;
          core_x_d = fifo_head;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        tmo_d   = '0;
      end
      WAIT_BUSY: begin
        // A core that never raises busy dropped the start; try again.
        if (core_busy_i) state_d = WAIT_DONE;
        else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) state_d = ISSUE;
        else tmo_d = tmo_q + 1'b1;
      end
      WAIT_DONE: begin
        if (!core_busy_i) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_src_d   = m_src_q;
    if (m_valid_q && m_ready_i) m_valid_d = 1'b0;
    if (capture) begin
      m_valid_d = 1'b1;
      m_data_d  = core_y_i;
      m_src_d   = fifo_head;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      core_x_q  <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_src_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      core_x_q  <= core_x_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_src_q   <= m_src_d;
    end
  end

  // Gating with busy guarantees no start ever reaches a running core.
  assign core_start_o = (state_q == ISSUE) && !core_busy_i;
  assign core_x_o     = core_x_q;
  assign m_valid_o    = m_valid_q;
  assign m_data_o     = m_data_q;
  assign m_src_o      = m_src_q;

`ifdef CBRT_RESULT_CHECK_EN
  logic                   err_q, err_d;
  logic [DATA_W-1:0]      err_cnt_q, err_cnt_d;
  logic [CBRT_DATA_W:0]   y_ext, y_nxt;
  logic [CUBE_W-1:0]      x_ext;
  logic                   mismatch;

  always_comb begin
    y_ext     = (CBRT_DATA_W + 1)'(core_y_i);
    y_nxt     = y_ext + 1'b1;
    x_ext     = CUBE_W'(fifo_head);
    mismatch  = capture && !((cube(y_ext) <= x_ext) && (x_ext < cube(y_nxt)));
    err_d     = err_q || mismatch;
    err_cnt_d = err_cnt_q;
    if (mismatch && (err_cnt_q != {DATA_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule
